// File: rtl/data_mem_responder.sv
// data_mem_responder: data-bus target for the core's MEM stage.
// Word RAM with posted stores, plus the machine timer registers.
module data_mem_responder #(
  parameter int XLEN = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_addr,
  input  logic            i_we,
  input  logic [2:0]      i_sel,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_fault,
  output logic            o_timer_irq
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] RAM_BYTES =
    XLEN'(4 * DEPTH_WORDS);

  typedef enum logic {
    S_IDLE,
    S_WPEND
  } state_t;

  logic [XLEN-1:0] r_mem [DEPTH_WORDS];

  state_t          r_state;
  logic [XLEN-1:0] r_p_addr;
  logic [3:0]      r_p_be;
  logic            r_p_ok;
  logic            r_fault;
  logic            r_irq;
  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;

  logic [1:0]      w_lane;
  logic            w_ram_hit;
  logic            w_mmio_hit;
  logic            w_bad_size;
  logic            w_is_w;
  logic            w_is_h;
  logic            w_misal;
  logic            w_ok;
  logic [3:0]      w_be;
  logic            w_commit;
  logic            w_p_mmio;
  logic            w_ram_we;
  logic [IW-1:0]   w_ridx;
  logic [IW-1:0]   w_pidx;
  logic [XLEN-1:0] w_wd_sh;
  logic [XLEN-1:0] w_bmask;
  logic [XLEN-1:0] w_mmio_word;
  logic [XLEN-1:0] w_raw;
  logic            w_byp;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_sh;
  logic [XLEN-1:0] w_ext;
  logic [63:0]     w_mtime_nx;
  logic [63:0]     w_cmp_nx;

  assign w_lane     = i_addr[1:0];
  assign w_ram_hit  = i_addr < RAM_BYTES;
  assign w_mmio_hit =
    i_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
  assign w_ridx     = i_addr[IW+1:2];
  assign w_pidx     = r_p_addr[IW+1:2];

  // Decode access size, alignment and mapping into a single legal flag
  always_comb begin
    w_bad_size = (i_sel == 3'b011) ||
                 (i_sel == 3'b110) ||
                 (i_sel == 3'b111);
    w_is_w  = i_sel == 3'b010;
    w_is_h  = i_sel[1:0] == 2'b01;
    w_misal = (w_is_h && w_lane[0]) ||
              (w_is_w && (w_lane != 2'd0));
    w_ok    = !w_bad_size && !w_misal &&
              (w_ram_hit || (w_mmio_hit && w_is_w));
    case (i_sel[1:0])
      2'b00:   w_be = 4'b0001 << w_lane;
      2'b01:   w_be = 4'b0011 << w_lane;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_commit = (r_state == S_WPEND) && r_p_ok;
  assign w_p_mmio =
    r_p_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
  assign w_ram_we = w_commit && !w_p_mmio;
  assign w_wd_sh  = i_wdata << {r_p_addr[1:0], 3'b000};
  assign w_bmask  = {{8{r_p_be[3]}}, {8{r_p_be[2]}},
                     {8{r_p_be[1]}}, {8{r_p_be[0]}}};

  // Fetch the addressed word, merge an in-flight store, then extract
  always_comb begin
    case (i_addr[3:2])
      2'd0:    w_mmio_word = r_mtime[31:0];
      2'd1:    w_mmio_word = r_mtime[63:32];
      2'd2:    w_mmio_word = r_mtimecmp[31:0];
      default: w_mmio_word = r_mtimecmp[63:32];
    endcase
    w_raw  = w_ram_hit ? r_mem[w_ridx] : w_mmio_word;
    w_byp  = w_commit &&
             (i_addr[XLEN-1:2] == r_p_addr[XLEN-1:2]);
    w_word = w_byp ? ((w_raw & ~w_bmask) |
                      (w_wd_sh & w_bmask)) : w_raw;
    w_sh   = w_word >> {w_lane, 3'b000};
    case (i_sel)
      3'b000:  w_ext = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_ext = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_sh[7:0]};
      3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_sh[15:0]};
      default: w_ext = w_sh;
    endcase
    o_rdata = w_ok ? w_ext : '0;
  end

  // Next timer values: a committed MMIO store overrides the tick
  always_comb begin
    w_mtime_nx = r_mtime + 64'd1;
    w_cmp_nx   = r_mtimecmp;
    if (w_commit && w_p_mmio) begin
      case (r_p_addr[3:2])
        2'd0:    w_mtime_nx = {r_mtime[63:32], i_wdata};
        2'd1:    w_mtime_nx = {i_wdata, r_mtime[31:0]};
        2'd2:    w_cmp_nx[31:0] = i_wdata;
        default: w_cmp_nx[63:32] = i_wdata;
      endcase
    end
  end

  // Posted-store FSM; also registers the access fault pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_p_addr <= '0;
      r_p_be   <= '0;
      r_p_ok   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_fault <= !w_ok;
      if (i_we) begin
        r_state  <= S_WPEND;
        r_p_addr <= i_addr;
        r_p_be   <= w_be;
        r_p_ok   <= w_ok;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  // Timer registers and interrupt on the post-edge values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_irq      <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nx;
      r_mtimecmp <= w_cmp_nx;
      r_irq      <= w_mtime_nx >= w_cmp_nx;
    end
  end

  // RAM byte-lane commit; reset clears the FSM so no write slips out
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (r_p_be[k])
          r_mem[w_pidx][8*k +: 8] <= w_wd_sh[8*k +: 8];
      end
    end
  end

  assign o_fault     = r_fault;
  assign o_timer_irq = r_irq;

endmodule
